instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters:
- DEPTH, 4, output buffer entries (power of 2, >=2).
- BASE_ADDR, 32'h0000_0000, first instruction-memory byte address.

REQ-002 Ports (clk and rst first):
- clk, in, 1: single clock; all state on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- clear, in, 1: synchronous flush.
- req_valid, in, 1: request present.
- req_ready, out, 1: encoder can accept.
- req_kind, in, 4: instruction kind (see REQ-006).
- req_rs, req_rt, req_rd, in, 5 each: register fields.
- req_funct, in, 6: R-type function code.
- req_imm, in, 16: immediate / offset.
- req_target, in, 26: jump target.
- iw_valid, out, 1: encoded word available.
- iw_ready, in, 1: memory write port accepts.
- iw_addr, out, 32: byte address of iw_data.
- iw_data, out, 32: encoded MIPS instruction word.
- bad_kind, out, 1: one-cycle pulse on dropped illegal request.
- count, out, log2(DEPTH)+1: buffered word count.

Function
REQ-003 Request handshake: accepted on a clk edge with req_valid && req_ready; req_ready = !full && !clear.
REQ-004 Output handshake: a word retires on a clk edge with iw_valid && iw_ready; iw_valid = (count != 0).
REQ-005 Latency: a word accepted at edge N drives iw_data at N+1 if the buffer was empty; otherwise order is strict FIFO.
REQ-006 Encoding, {op,rs,rt,rd,shamt=0,funct} or {op,rs,rt,imm} or {op,target}:
- 0 R-type: op 000000, funct=req_funct.
- 1 addi 001000; 2 andi 001100; 3 ori 001101; 4 xori 001110; 5 slti 001010 (I-form).
- 6 beq 000100 (I-form).
- 7 j 000010; 8 jal 000011 (J-form).
- 9 lw 100011; 10 sw 101011 (I-form).
- 11 jr: op 0, rs=req_rs, rt=rd=0, funct 001000.
- 12 jalr: see REQ-014.
- 13-15: illegal.
REQ-007 Illegal kind with req_valid && req_ready: request consumed, nothing buffered, bad_kind=1 next cycle only.
REQ-008 iw_addr: the address counter starts at BASE_ADDR and advances by 4 per retired word; the head word is output at the current counter value; wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-009 Buffer full (count==DEPTH): req_ready=0; a simultaneous retire does not enable a same-cycle accept.
REQ-010 Buffer empty with simultaneous accept: word buffered; no retire that cycle.
REQ-011 Simultaneous accept and retire with 0<count<DEPTH: count unchanged.
REQ-012 clear=1: FIFO emptied, address counter set to BASE_ADDR, and no accept or retire that edge; clear overrides all other inputs.

Reset
REQ-013 rst asserted (any time, including mid-transfer): count=0, iw_valid=0, iw_data=0, iw_addr=BASE_ADDR, bad_kind=0, req_ready=1 after release; buffered words are discarded.

Configuration
REQ-014 Macro INSTR_ENCODER_JALR_EN:
- Defined: kind 12 encodes jalr as op 0, rs=req_rs, rt=0, rd=req_rd, funct 001001.
- Undefined: kind 12 is illegal per REQ-007.

Verification
REQ-015 Reset, then addi kind 1 with rs=1, rt=2, imm=16'h0005, iw_ready=1: iw_data=32'h2022_0005 and iw_addr=0 one cycle after acceptance.
REQ-016 Four words pushed with iw_ready=0: count=4, req_ready=0, fifth request stalls; then iw_ready=1 retires them in order at addresses 0,4,8,C.
REQ-017 Kind 14, and kind 12 without the macro: no word buffered, bad_kind high exactly one cycle, next legal word still at its expected address.
REQ-018 Reset, then jal with target=26'h000_0010: iw_data=32'h0C00_0010; with the macro, jalr rs=31, rd=5: iw_data=32'h03E0_2809.
REQ-019 BASE_ADDR=32'hFFFF_FFFC with two words retired: addresses FFFF_FFFC then 0000_0000; clear or rst asserted with 3 words buffered empties the FIFO, and the next word is at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder feeding a FIFO-buffered memory write port
// Optional jalr encoding (kind 12) is enabled by defining INSTR_ENCODER_JALR_EN.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_kind,
    input  logic [4:0]                 req_rs,
    input  logic [4:0]                 req_rt,
    input  logic [4:0]                 req_rd,
    input  logic [5:0]                 req_funct,
    input  logic [15:0]                req_imm,
    input  logic [25:0]                req_target,
    output logic                       iw_valid,
    input  logic                       iw_ready,
    output logic [31:0]                iw_addr,
    output logic [31:0]                iw_data,
    output logic                       bad_kind,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   addr_q;
    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    logic          legal;
    logic [31:0]   enc_word;

    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        case (req_kind)
            4'd0:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, req_funct};
            4'd1:  enc_word = {6'b001000, req_rs, req_rt, req_imm};
            4'd2:  enc_word = {6'b001100, req_rs, req_rt, req_imm};
            4'd3:  enc_word = {6'b001101, req_rs, req_rt, req_imm};
            4'd4:  enc_word = {6'b001110, req_rs, req_rt, req_imm};
            4'd5:  enc_word = {6'b001010, req_rs, req_rt, req_imm};
            4'd6:  enc_word = {6'b000100, req_rs, req_rt, req_imm};
            4'd7:  enc_word = {6'b000010, req_target};
            4'd8:  enc_word = {6'b000011, req_target};
            4'd9:  enc_word = {6'b100011, req_rs, req_rt, req_imm};
            4'd10: enc_word = {6'b101011, req_rs, req_rt, req_imm};
            4'd11: enc_word = {6'b000000, req_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
`ifdef INSTR_ENCODER_JALR_EN
            4'd12: enc_word = {6'b000000, req_rs, 5'd0, req_rd, 5'd0, 6'b001001};
`else
            4'd12: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
    end

    assign full      = (count == (AW+1)'(DEPTH));
    assign req_ready = !full && !clear;
    assign iw_valid  = (count != '0);
    assign accept    = req_valid && req_ready;
    // Illegal requests are consumed but never occupy a slot.
    assign push      = accept && legal;
    assign pop       = iw_valid && iw_ready && !clear;
    assign iw_addr   = addr_q;
    assign iw_data   = iw_valid ? mem[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_q   <= BASE_ADDR;
            bad_kind <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_q   <= BASE_ADDR;
            bad_kind <= 1'b0;
        end else begin
            bad_kind <= accept && !legal;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        req_valid;
    logic        req_ready, req_ready_w;
    logic [3:0]  req_kind;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [5:0]  req_funct;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        iw_valid, iw_valid_w;
    logic        iw_ready;
    logic [31:0] iw_addr, iw_addr_w;
    logic [31:0] iw_data, iw_data_w;
    logic        bad_kind, bad_kind_w;
    logic [2:0]  count, count_w;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct),
        .req_imm(req_imm), .req_target(req_target),
        .iw_valid(iw_valid), .iw_ready(iw_ready), .iw_addr(iw_addr), .iw_data(iw_data),
        .bad_kind(bad_kind), .count(count)
    );

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready_w), .req_kind(req_kind),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct),
        .req_imm(req_imm), .req_target(req_target),
        .iw_valid(iw_valid_w), .iw_ready(iw_ready), .iw_addr(iw_addr_w), .iw_data(iw_data_w),
        .bad_kind(bad_kind_w), .count(count_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                           input logic [25:0] target);
        req_kind   = kind;
        req_rs     = rs;
        req_rt     = rt;
        req_rd     = rd;
        req_funct  = funct;
        req_imm    = imm;
        req_target = target;
    endtask

    task automatic push(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                        input logic [25:0] target);
        set_req(kind, rs, rt, rd, funct, imm, target);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Push one word into an empty FIFO, check its encoding, then drain it.
    task automatic enc_check(input string tag, input logic [3:0] kind, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
                             input logic [15:0] imm, input logic [25:0] target,
                             input logic [31:0] exp);
        iw_ready = 1'b0;
        push(kind, rs, rt, rd, funct, imm, target);
        check(tag, iw_data, exp);
        iw_ready = 1'b1;
        tick();
        iw_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; req_valid = 1'b0; iw_ready = 1'b0;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_iw_valid", 32'(iw_valid), 32'd0);
        check("rst_iw_data", iw_data, 32'd0);
        check("rst_iw_addr", iw_addr, 32'h0000_0000);
        check("rst_iw_addr_w", iw_addr_w, 32'hFFFF_FFFC);
        check("rst_bad_kind", 32'(bad_kind), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // addi with sink ready: visible one cycle after acceptance
        iw_ready = 1'b1;
        push(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
        check("addi_valid", 32'(iw_valid), 32'd1);
        check("addi_data", iw_data, 32'h2022_0005);
        check("addi_addr", iw_addr, 32'h0000_0000);
        tick();
        check("addi_retired_count", 32'(count), 32'd0);
        check("addi_next_addr", iw_addr, 32'h0000_0004);

        // Fill to DEPTH with sink stalled
        do_reset();
        iw_ready = 1'b0;
        push(4'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
        push(4'd3, 5'd0, 5'd4, 5'd0, 6'd0, 16'h1234, 26'd0);
        push(4'd9, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0010, 26'd0);
        push(4'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0040);
        check("full_count", 32'(count), 32'd4);
        check("full_req_ready", 32'(req_ready), 32'd0);
        set_req(4'd2, 5'd3, 5'd3, 5'd0, 6'd0, 16'h00FF, 26'd0);
        req_valid = 1'b1;
        tick();
        check("fifth_stalls", 32'(count), 32'd4);
        check("head0_data", iw_data, 32'h0022_1820);
        check("head0_addr", iw_addr, 32'h0000_0000);
        iw_ready = 1'b1;
        tick();
        check("full_retire_no_accept", 32'(count), 32'd3);
        req_valid = 1'b0;
        check("head1_data", iw_data, 32'h3404_1234);
        check("head1_addr", iw_addr, 32'h0000_0004);
        tick();
        check("head2_data", iw_data, 32'h8FA8_0010);
        check("head2_addr", iw_addr, 32'h0000_0008);
        tick();
        check("head3_data", iw_data, 32'h0800_0040);
        check("head3_addr", iw_addr, 32'h0000_000C);
        tick();
        check("drained_valid", 32'(iw_valid), 32'd0);
        check("drained_addr", iw_addr, 32'h0000_0010);

        // Simultaneous accept and retire keeps count steady
        do_reset();
        iw_ready = 1'b0;
        push(4'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0);
        push(4'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0);
        iw_ready = 1'b1;
        push(4'd1, 5'd0, 5'd3, 5'd0, 6'd0, 16'h0003, 26'd0);
        check("acc_ret_count", 32'(count), 32'd2);
        check("acc_ret_head", iw_data, 32'h2002_0002);

        // Illegal kinds
        do_reset();
        iw_ready = 1'b1;
        push(4'd14, 5'd1, 5'd1, 5'd1, 6'd0, 16'd0, 26'd0);
        check("k14_bad", 32'(bad_kind), 32'd1);
        check("k14_count", 32'(count), 32'd0);
        tick();
        check("k14_bad_pulse_end", 32'(bad_kind), 32'd0);
        push(4'd12, 5'd31, 5'd0, 5'd5, 6'd0, 16'd0, 26'd0);
`ifdef INSTR_ENCODER_JALR_EN
        check("jalr_bad", 32'(bad_kind), 32'd0);
        check("jalr_data", iw_data, 32'h03E0_2809);
        tick();
        push(4'd4, 5'd5, 5'd6, 5'd0, 6'd0, 16'hABCD, 26'd0);
        check("after_bad_data", iw_data, 32'h38A6_ABCD);
        check("after_bad_addr", iw_addr, 32'h0000_0004);
`else
        check("k12_bad", 32'(bad_kind), 32'd1);
        check("k12_count", 32'(count), 32'd0);
        push(4'd4, 5'd5, 5'd6, 5'd0, 6'd0, 16'hABCD, 26'd0);
        check("k12_bad_pulse_end", 32'(bad_kind), 32'd0);
        check("after_bad_data", iw_data, 32'h38A6_ABCD);
        check("after_bad_addr", iw_addr, 32'h0000_0000);
`endif
        tick();

        // Encoding table
        do_reset();
        enc_check("jal", 4'd8, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0010, 32'h0C00_0010);
        enc_check("beq", 4'd6, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 26'd0, 32'h1022_FFFE);
        enc_check("jr", 4'd11, 5'd31, 5'd7, 5'd9, 6'h3F, 16'd0, 26'd0, 32'h03E0_0008);
        enc_check("slti", 4'd5, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0007, 26'd0, 32'h2843_0007);
        enc_check("sw", 4'd10, 5'd29, 5'd31, 5'd0, 6'd0, 16'h0004, 26'd0, 32'hAFBF_0004);
        enc_check("andi", 4'd2, 5'd3, 5'd3, 5'd0, 6'd0, 16'h00FF, 26'd0, 32'h3063_00FF);

        // clear with 3 words buffered, address counter already advanced
        do_reset();
        iw_ready = 1'b0;
        push(4'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0);
        push(4'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0);
        push(4'd1, 5'd0, 5'd3, 5'd0, 6'd0, 16'h0003, 26'd0);
        push(4'd1, 5'd0, 5'd4, 5'd0, 6'd0, 16'h0004, 26'd0);
        iw_ready = 1'b1;
        tick();
        check("pre_clear_count", 32'(count), 32'd3);
        check("pre_clear_addr", iw_addr, 32'h0000_0004);
        clear = 1'b1;
        req_valid = 1'b1;
        #1;
        check("clear_req_ready", 32'(req_ready), 32'd0);
        tick();
        clear = 1'b0;
        req_valid = 1'b0;
        check("clear_count", 32'(count), 32'd0);
        check("clear_addr", iw_addr, 32'h0000_0000);
        iw_ready = 1'b0;
        push(4'd3, 5'd0, 5'd4, 5'd0, 6'd0, 16'h1234, 26'd0);
        check("post_clear_data", iw_data, 32'h3404_1234);
        check("post_clear_addr", iw_addr, 32'h0000_0000);

        // Asynchronous reset mid-transfer
        push(4'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0);
        push(4'd1, 5'd0, 5'd3, 5'd0, 6'd0, 16'h0003, 26'd0);
        iw_ready = 1'b1;
        tick();
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_addr", iw_addr, 32'h0000_0000);
        check("async_rst_data", iw_data, 32'd0);
        tick();
        rst = 1'b0;
        iw_ready = 1'b0;
        push(4'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0);
        check("post_rst_addr", iw_addr, 32'h0000_0000);
        check("post_rst_data", iw_data, 32'h2022_0005);

        // Address wrap on the high-base instance
        do_reset();
        iw_ready = 1'b0;
        push(4'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0);
        push(4'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0);
        check("wrap_addr0", iw_addr_w, 32'hFFFF_FFFC);
        check("wrap_data0", iw_data_w, 32'h2001_0001);
        iw_ready = 1'b1;
        tick();
        check("wrap_addr1", iw_addr_w, 32'h0000_0000);
        check("wrap_data1", iw_data_w, 32'h2002_0002);
        tick();
        check("wrap_addr2", iw_addr_w, 32'h0000_0004);
        check("wrap_empty", 32'(iw_valid_w), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
